twi_slave_logic: RTL and testbench

TWI/I2C responder for the far end of the bus driven by the team's TWI master core. Detects START/STOP, matches a 7-bit address, acknowledges, and turns bus transfers into byte-wide register writes and reads on a simple local port with an auto-incrementing pointer. Sits between the board-level open-drain SCL/SDA pads and a local register bank or FIFO.

---
 rtl/twi_pkg.sv | 27 ++
 rtl/twi_line_filter.sv | 72 +++++++
 rtl/twi_slave_logic.sv | 256 +++++++++++++++++++++++++
 tb/tb_twi_slave_logic.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/twi_pkg.sv
// Shared types and constants for the TWI responder: FSM state encoding,
// bus acknowledge levels and the address-match helper.
package twi_pkg;

  localparam int   TWI_BYTE_W = 8;
  localparam logic TWI_ACK    = 1'b0;
  localparam logic TWI_NACK   = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_IGNORE    = 4'd9
  } twi_state_e;

  function automatic logic twi_addr_match(input logic [6:0] addr_field,
                                          input logic [6:0] slave_addr);
    return (addr_field == slave_addr);
  endfunction

endpackage

// File: rtl/twi_line_filter.sv
// Pad-line conditioner: 2-flop synchronizer, optional glitch filter
// (TWI_SLAVE_GLITCH_FILTER_EN) and rise/fall pulses of the accepted level.
module twi_line_filter
`ifdef TWI_SLAVE_GLITCH_FILTER_EN
#(
  parameter int FILTER_LEN = 3
)
`endif
(
  input  logic iClk,
  input  logic iResetN,
  input  logic iLine,
  output logic oLevel,
  output logic oRise,
  output logic oFall
);

  logic [1:0] r_sync;
  logic       r_prev;
  logic       w_level;

  // Two-flop synchronizer; idle bus level is high.
  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], iLine};
    end
  end

`ifdef TWI_SLAVE_GLITCH_FILTER_EN
  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  // Accept a new level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) begin
      r_cnt   <= '0;
      r_level <= 1'b1;
    end else if (r_sync[1] != r_level) begin
      if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_level = r_level;
`else
  assign w_level = r_sync[1];
`endif

  // Previous accepted level for edge detection.
  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= w_level;
    end
  end

  assign oLevel = w_level;
  assign oRise  = w_level & ~r_prev;
  assign oFall  = ~w_level & r_prev;

endmodule

// File: rtl/twi_slave_logic.sv
// TWI/I2C responder turning bus transfers into local register writes/reads
// with an auto-incrementing pointer. Optional input glitch filter: TWI_SLAVE_GLITCH_FILTER_EN.
module twi_slave_logic
  import twi_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
`ifdef TWI_SLAVE_GLITCH_FILTER_EN
  , parameter int FILTER_LEN = 3
`endif
)(
  input  logic                  iClk,
  input  logic                  iResetN,
  input  logic                  iScl,
  input  logic                  iSda,
  output logic                  oSdaLow,
  output logic                  oBusy,
  output logic                  oWrValid,
  output logic [TWI_BYTE_W-1:0] oWrAddr,
  output logic [TWI_BYTE_W-1:0] oWrData,
  output logic                  oRdStrobe,
  output logic [TWI_BYTE_W-1:0] oRdAddr,
  input  logic [TWI_BYTE_W-1:0] iRdData
);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;

  twi_state_e            r_state, w_state_nxt;
  logic [2:0]            r_bit_cnt, w_bit_cnt_nxt;
  logic [6:0]            r_shift, w_shift_nxt;
  logic [6:0]            r_tx, w_tx_nxt;
  logic [TWI_BYTE_W-1:0] r_ptr, w_ptr_nxt;
  logic [TWI_BYTE_W-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [TWI_BYTE_W-1:0] r_wr_data, w_wr_data_nxt;
  logic                  r_rw, w_rw_nxt;
  logic                  r_phase, w_phase_nxt;
  logic                  r_sda_low, w_sda_low_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_wr_valid, w_wr_valid_nxt;
  logic                  r_rd_strobe, w_rd_strobe_nxt;
  logic [TWI_BYTE_W-1:0] w_byte;

`ifdef TWI_SLAVE_GLITCH_FILTER_EN
  twi_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
`else
  twi_line_filter u_scl_filter (
`endif
    .iClk    (iClk),
    .iResetN (iResetN),
    .iLine   (iScl),
    .oLevel  (w_scl),
    .oRise   (w_scl_rise),
    .oFall   (w_scl_fall)
  );

`ifdef TWI_SLAVE_GLITCH_FILTER_EN
  twi_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
`else
  twi_line_filter u_sda_filter (
`endif
    .iClk    (iClk),
    .iResetN (iResetN),
    .iLine   (iSda),
    .oLevel  (w_sda),
    .oRise   (w_sda_rise),
    .oFall   (w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;
  assign w_byte  = {r_shift, w_sda};

  // State and datapath registers.
  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 7'd0;
      r_tx        <= 7'd0;
      r_ptr       <= 8'd0;
      r_wr_addr   <= 8'd0;
      r_wr_data   <= 8'd0;
      r_rw        <= 1'b0;
      r_phase     <= 1'b0;
      r_sda_low   <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_rd_strobe <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_tx        <= w_tx_nxt;
      r_ptr       <= w_ptr_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_rw        <= w_rw_nxt;
      r_phase     <= w_phase_nxt;
      r_sda_low   <= w_sda_low_nxt;
      r_busy      <= w_busy_nxt;
      r_wr_valid  <= w_wr_valid_nxt;
      r_rd_strobe <= w_rd_strobe_nxt;
    end
  end

  // Next-state logic; START/STOP outrank any SCL edge in the same cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_tx_nxt        = r_tx;
    w_ptr_nxt       = r_ptr;
    w_wr_addr_nxt   = r_wr_addr;
    w_wr_data_nxt   = r_wr_data;
    w_rw_nxt        = r_rw;
    w_phase_nxt     = r_phase;
    w_sda_low_nxt   = r_sda_low;
    w_busy_nxt      = r_busy;
    w_wr_valid_nxt  = 1'b0;
    w_rd_strobe_nxt = 1'b0;

    if (w_stop) begin
      w_state_nxt   = ST_IDLE;
      w_sda_low_nxt = 1'b0;
      w_busy_nxt    = 1'b0;
      w_phase_nxt   = 1'b0;
    end else if (w_start) begin
      w_state_nxt   = ST_ADDR;
      w_bit_cnt_nxt = 3'd0;
      w_sda_low_nxt = 1'b0;
      w_phase_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_byte[6:0];
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            w_phase_nxt   = 1'b0;
            if (r_bit_cnt == 3'd7) begin
              w_rw_nxt = w_sda;
              if (twi_addr_match(w_byte[7:1], SLAVE_ADDR)) begin
                w_state_nxt = ST_ADDR_ACK;
                w_busy_nxt  = 1'b1;
              end else begin
                w_state_nxt = ST_IGNORE;
                w_busy_nxt  = 1'b0;
              end
            end else begin
              w_state_nxt = ST_ADDR;
            end
          end else begin
            w_state_nxt = ST_ADDR;
          end
        end

        // Phase 0: start ACK at the fall after bit 8; phase 1: end it at the next fall.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (w_scl_fall && !r_phase) begin
            w_sda_low_nxt = ~TWI_ACK;
            w_phase_nxt   = 1'b1;
          end else if (w_scl_fall) begin
            w_phase_nxt   = 1'b0;
            w_bit_cnt_nxt = 3'd0;
            if (r_state == ST_ADDR_ACK && r_rw) begin
              w_state_nxt     = ST_RDATA;
              w_rd_strobe_nxt = 1'b1;
            end else begin
              w_state_nxt   = (r_state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
              w_sda_low_nxt = 1'b0;
            end
          end else begin
            w_phase_nxt = r_phase;
          end
        end

        ST_PTR, ST_WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_byte[6:0];
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            w_phase_nxt   = 1'b0;
            if (r_bit_cnt == 3'd7 && r_state == ST_PTR) begin
              w_ptr_nxt   = w_byte;
              w_state_nxt = ST_PTR_ACK;
            end else if (r_bit_cnt == 3'd7) begin
              w_wr_valid_nxt = 1'b1;
              w_wr_addr_nxt  = r_ptr;
              w_wr_data_nxt  = w_byte;
              w_ptr_nxt      = r_ptr + 8'd1;
              w_state_nxt    = ST_WDATA_ACK;
            end else begin
              w_state_nxt = r_state;
            end
          end else begin
            w_state_nxt = r_state;
          end
        end

        // The strobe cycle captures iRdData and puts its MSB on the bus.
        ST_RDATA: begin
          if (r_rd_strobe) begin
            w_tx_nxt      = iRdData[6:0];
            w_sda_low_nxt = ~iRdData[7];
            w_ptr_nxt     = r_ptr + 8'd1;
            w_bit_cnt_nxt = 3'd0;
          end else if (w_scl_fall && r_bit_cnt == 3'd7) begin
            w_sda_low_nxt = 1'b0;
            w_phase_nxt   = 1'b0;
            w_state_nxt   = ST_RDATA_ACK;
          end else if (w_scl_fall) begin
            w_sda_low_nxt = ~r_tx[6];
            w_tx_nxt      = {r_tx[5:0], 1'b0};
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end else begin
            w_tx_nxt = r_tx;
          end
        end

        ST_RDATA_ACK: begin
          if (w_scl_rise && !r_phase) begin
            if (w_sda == TWI_NACK) begin
              w_state_nxt = ST_IGNORE;
            end else begin
              w_phase_nxt = 1'b1;
            end
          end else if (w_scl_fall && r_phase) begin
            w_phase_nxt     = 1'b0;
            w_rd_strobe_nxt = 1'b1;
            w_state_nxt     = ST_RDATA;
          end else begin
            w_phase_nxt = r_phase;
          end
        end

        ST_IDLE, ST_IGNORE: begin
          w_sda_low_nxt = 1'b0;
        end

        default: begin
          w_state_nxt   = ST_IDLE;
          w_sda_low_nxt = 1'b0;
          w_busy_nxt    = 1'b0;
        end
      endcase
    end
  end

  assign oSdaLow   = r_sda_low;
  assign oBusy     = r_busy;
  assign oWrValid  = r_wr_valid;
  assign oWrAddr   = r_wr_addr;
  assign oWrData   = r_wr_data;
  assign oRdStrobe = r_rd_strobe;
  assign oRdAddr   = r_ptr;

endmodule

// File: tb/tb_twi_slave_logic.sv
// Directed bench for twi_slave_logic: a bit-banged bus master with an
// open-drain SDA model and a monitor for the local write/read port.
module tb_twi_slave_logic;

  localparam int Q = 5;
  localparam int H = 10;

  logic       iClk = 1'b0;
  logic       iResetN;
  logic       m_scl;
  logic       m_sda;
  logic       sda_bus;
  logic       oSdaLow, oBusy, oWrValid, oRdStrobe;
  logic [7:0] oWrAddr, oWrData, oRdAddr, iRdData;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          rd_cnt   = 0;
  logic [15:0] wr_q[$];

  assign sda_bus = m_sda & ~oSdaLow;
  assign iRdData = ~oRdAddr;

  twi_slave_logic dut (
    .iClk      (iClk),
    .iResetN   (iResetN),
    .iScl      (m_scl),
    .iSda      (sda_bus),
    .oSdaLow   (oSdaLow),
    .oBusy     (oBusy),
    .oWrValid  (oWrValid),
    .oWrAddr   (oWrAddr),
    .oWrData   (oWrData),
    .oRdStrobe (oRdStrobe),
    .oRdAddr   (oRdAddr),
    .iRdData   (iRdData)
  );

  always #5 iClk = ~iClk;

  always @(negedge iClk) begin
    if (oWrValid) wr_q.push_back({oWrAddr, oWrData});
    if (oRdStrobe) rd_cnt++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wr_entry(input int i);
    if (i < wr_q.size()) return {16'd0, wr_q[i]};
    else return 32'hFFFF_FFFF;
  endfunction

  task automatic bus_start();
    m_sda = 1'b1; wait_cyc(Q);
    m_scl = 1'b1; wait_cyc(Q);
    m_sda = 1'b0; wait_cyc(Q);
    m_scl = 1'b0; wait_cyc(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_cyc(Q);
    m_scl = 1'b1; wait_cyc(Q);
    m_sda = 1'b1; wait_cyc(H);
  endtask

  task automatic write_bit(input logic b, input logic glitch);
    m_sda = b;
    if (glitch) begin
      wait_cyc(1);
      m_scl = 1'b1; wait_cyc(2);
      m_scl = 1'b0; wait_cyc(Q - 3);
    end else begin
      wait_cyc(Q);
    end
    m_scl = 1'b1; wait_cyc(H);
    m_scl = 1'b0; wait_cyc(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wait_cyc(Q);
    m_scl = 1'b1; wait_cyc(H / 2);
    b = sda_bus;  wait_cyc(H / 2);
    m_scl = 1'b0; wait_cyc(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i], (i == glitch_bit));
    read_bit(ack);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack, 1'b0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    logic [3:0] nib;
    logic       b;

    iResetN = 1'b0;
    m_scl   = 1'b1;
    m_sda   = 1'b1;
    wait_cyc(3);
    chk("rst_sdalow", oSdaLow, 1'b0);
    chk("rst_busy", oBusy, 1'b0);
    chk("rst_wrvalid", oWrValid, 1'b0);
    chk("rst_rdstrobe", oRdStrobe, 1'b0);
    chk("rst_wraddr", oWrAddr, 8'h00);
    chk("rst_wrdata", oWrData, 8'h00);
    chk("rst_rdaddr", oRdAddr, 8'h00);
    iResetN = 1'b1;
    wait_cyc(H);

    // Plain write of two bytes at pointer 0x10
    wr_q.delete();
    bus_start();
    write_byte(8'hA0, -1, ack); chk("w1_ack_addr", ack, 1'b0);
    chk("w1_busy", oBusy, 1'b1);
    write_byte(8'h10, -1, ack); chk("w1_ack_ptr", ack, 1'b0);
    write_byte(8'h55, -1, ack); chk("w1_ack_d0", ack, 1'b0);
    write_byte(8'h66, -1, ack); chk("w1_ack_d1", ack, 1'b0);
    bus_stop();
    chk("w1_busy_after_stop", oBusy, 1'b0);
    chk("w1_wr_count", wr_q.size(), 2);
    chk("w1_wr0", wr_entry(0), 32'h0000_1055);
    chk("w1_wr1", wr_entry(1), 32'h0000_1166);

    // Set pointer 0x20, repeated START, read two bytes
    wr_q.delete(); rd_cnt = 0;
    bus_start();
    write_byte(8'hA0, -1, ack); chk("r_ack_waddr", ack, 1'b0);
    write_byte(8'h20, -1, ack); chk("r_ack_ptr", ack, 1'b0);
    bus_start();
    write_byte(8'hA1, -1, ack); chk("r_ack_raddr", ack, 1'b0);
    chk("r_busy", oBusy, 1'b1);
    read_byte(1'b0, rd); chk("r_byte0", rd, 8'hDF);
    read_byte(1'b1, rd); chk("r_byte1", rd, 8'hDE);
    chk("r_sda_released", oSdaLow, 1'b0);
    chk("r_strobe_count", rd_cnt, 2);
    chk("r_rdaddr", oRdAddr, 8'h22);
    bus_stop();
    chk("r_busy_after_stop", oBusy, 1'b0);
    chk("r_no_writes", wr_q.size(), 0);

    // Foreign address: no ACK, no strobes
    wr_q.delete(); rd_cnt = 0;
    bus_start();
    write_byte(8'hA2, -1, ack); chk("na_nack_addr", ack, 1'b1);
    chk("na_busy", oBusy, 1'b0);
    write_byte(8'h33, -1, ack); chk("na_nack_data", ack, 1'b1);
    bus_stop();
    chk("na_no_writes", wr_q.size(), 0);
    chk("na_no_reads", rd_cnt, 0);

    // Pointer wrap 0xFF -> 0x00
    wr_q.delete();
    bus_start();
    write_byte(8'hA0, -1, ack); chk("wrap_ack_addr", ack, 1'b0);
    write_byte(8'hFF, -1, ack); chk("wrap_ack_ptr", ack, 1'b0);
    write_byte(8'hAB, -1, ack); chk("wrap_ack_d0", ack, 1'b0);
    write_byte(8'hCD, -1, ack); chk("wrap_ack_d1", ack, 1'b0);
    bus_stop();
    chk("wrap_wr0", wr_entry(0), 32'h0000_FFAB);
    chk("wrap_wr1", wr_entry(1), 32'h0000_00CD);
    chk("wrap_rdaddr", oRdAddr, 8'h01);

    // Reset during the 5th bit of a read byte (0xC7, that bit drives low)
    bus_start();
    write_byte(8'hA0, -1, ack); chk("rst_t_ack_addr", ack, 1'b0);
    write_byte(8'h38, -1, ack); chk("rst_t_ack_ptr", ack, 1'b0);
    bus_start();
    write_byte(8'hA1, -1, ack); chk("rst_t_ack_raddr", ack, 1'b0);
    nib = 4'h0;
    for (int i = 0; i < 4; i++) begin
      read_bit(b);
      nib = {nib[2:0], b};
    end
    chk("rst_t_high_nibble", nib, 4'hC);
    m_sda = 1'b1; wait_cyc(Q);
    m_scl = 1'b1; wait_cyc(3);
    chk("rst_t_driving", oSdaLow, 1'b1);
    chk("rst_t_busy_before", oBusy, 1'b1);
    iResetN = 1'b0;
    #1;
    chk("rst_t_sda_released", oSdaLow, 1'b0);
    chk("rst_t_busy_cleared", oBusy, 1'b0);
    chk("rst_t_rdaddr_cleared", oRdAddr, 8'h00);
    wait_cyc(4);
    m_scl = 1'b0; wait_cyc(Q);
    iResetN = 1'b1; wait_cyc(Q);
    bus_stop();
    wr_q.delete();
    bus_start();
    write_byte(8'hA0, -1, ack); chk("post_rst_ack_addr", ack, 1'b0);
    write_byte(8'h40, -1, ack); chk("post_rst_ack_ptr", ack, 1'b0);
    write_byte(8'h77, -1, ack); chk("post_rst_ack_d0", ack, 1'b0);
    bus_stop();
    chk("post_rst_wr_count", wr_q.size(), 1);
    chk("post_rst_wr0", wr_entry(0), 32'h0000_4077);

`ifdef TWI_SLAVE_GLITCH_FILTER_EN
    // Two-cycle SCL glitch inside the data byte must not add a bit
    wr_q.delete();
    bus_start();
    write_byte(8'hA0, -1, ack); chk("gl_ack_addr", ack, 1'b0);
    write_byte(8'h50, -1, ack); chk("gl_ack_ptr", ack, 1'b0);
    write_byte(8'h5A, 3, ack);  chk("gl_ack_d0", ack, 1'b0);
    bus_stop();
    chk("gl_wr_count", wr_q.size(), 1);
    chk("gl_wr0", wr_entry(0), 32'h0000_505A);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
